// File: rtl/delay.sv
// ============================================================================
// delay : NUM_STAGES-deep shift register; optional stall input under DELAY_STALL_EN
// Revision: 1.0
// ============================================================================
`default_nettype none

module delay #(
  parameter int NUM_STAGES = 1,
  parameter int DATA_WIDTH = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
`ifdef DELAY_STALL_EN
  input  logic                  en,
`endif
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);

  if (NUM_STAGES < 0 || NUM_STAGES > 64) begin : g_bad_stages
    $error("delay: NUM_STAGES=%0d outside 0..64", NUM_STAGES);
  end
  if (DATA_WIDTH < 1 || DATA_WIDTH > 1024) begin : g_bad_width
    $error("delay: DATA_WIDTH=%0d outside 1..1024", DATA_WIDTH);
  end

  if (NUM_STAGES == 0) begin : g_comb
    // Pure wire: clock, reset and stall have no effect in this configuration.
`ifdef DELAY_STALL_EN
    logic w_unused_ok;
    assign w_unused_ok = ^{clk, rst_n, en};
`else
    logic w_unused_ok;
    assign w_unused_ok = ^{clk, rst_n};
`endif
    assign dout = din;
  end else begin : g_regs
    logic [DATA_WIDTH-1:0] r_stages [NUM_STAGES];
    logic                  w_shift;

`ifdef DELAY_STALL_EN
    assign w_shift = en;
`else
    assign w_shift = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int k = 0; k < NUM_STAGES; k++) begin
          r_stages[k] <= '0;
        end
      end else if (w_shift) begin
        r_stages[0] <= din;
        for (int k = 1; k < NUM_STAGES; k++) begin
          r_stages[k] <= r_stages[k-1];
        end
      end
    end

    assign dout = r_stages[NUM_STAGES-1];
  end

endmodule

`default_nettype wire

// File: tb/tb_delay.sv
// ============================================================================
// tb_delay : scoreboard bench for delay (3x8, 1x1 and 0x16 instances)
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_delay;

  localparam int c_N = 3;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [7:0]  din;
  logic [7:0]  dout;
  logic        din1;
  logic        dout1;
  logic [15:0] din16;
  logic [15:0] dout16;

  int tests = 0;
  int fails = 0;

  logic [7:0] hist [$];
  logic       prev1;
  logic [7:0] exp_q [$];
  logic       exp1_q [$];

  delay #(.NUM_STAGES(c_N), .DATA_WIDTH(8)) u_dut (
    .clk(clk), .rst_n(rst_n),
`ifdef DELAY_STALL_EN
    .en(en),
`endif
    .din(din), .dout(dout));

  delay #(.NUM_STAGES(1), .DATA_WIDTH(1)) u_one (
    .clk(clk), .rst_n(rst_n),
`ifdef DELAY_STALL_EN
    .en(en),
`endif
    .din(din1), .dout(dout1));

  delay #(.NUM_STAGES(0), .DATA_WIDTH(16)) u_comb (
    .clk(clk), .rst_n(rst_n),
`ifdef DELAY_STALL_EN
    .en(en),
`endif
    .din(din16), .dout(dout16));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: output is the input seen c_N enabled edges ago, zero-filled after reset.
  task automatic model_clear();
    hist = {};
    for (int i = 0; i < c_N; i++) hist.push_back(8'h00);
    prev1 = 1'b0;
  endtask

  initial model_clear();

  always @(posedge clk) begin
    if (!rst_n) begin
      model_clear();
    end else if (en) begin
      hist.push_back(din);
      void'(hist.pop_front());
      prev1 = din1;
    end
    exp_q.push_back(hist[0]);
    exp1_q.push_back(prev1);
  end

  always @(posedge clk) begin
    #1;
    if (exp_q.size() == 0 || exp1_q.size() == 0) begin
      check("scoreboard_empty", 32'd0, 32'd1);
    end else begin
      check("dout_n3", {24'd0, dout}, {24'd0, exp_q.pop_front()});
      check("dout_n1", {31'd0, dout1}, {31'd0, exp1_q.pop_front()});
    end
  end

  task automatic mid_reset();
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_dout_n3", {24'd0, dout}, 32'd0);
    check("async_rst_dout_n1", {31'd0, dout1}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b1;
    en    = 1'b1;
    din   = 8'h00;
    din1  = 1'b0;
    din16 = 16'h1234;
    #1;
    check("comb_0x1234", {16'd0, dout16}, 32'h1234);
    #1 rst_n = 1'b0;
    #1;
    check("reset_dout_n3", {24'd0, dout}, 32'd0);
    check("reset_dout_n1", {31'd0, dout1}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Single-cycle pulse on the 1x1 instance, counting sequence on the 3x8.
    din  = 8'h01;
    din1 = 1'b1;
    for (int i = 2; i <= 10; i++) begin
      @(negedge clk);
      din  = 8'(i);
      din1 = 1'b0;
    end
    repeat (4) begin
      @(negedge clk);
      din = 8'h00;
    end

    // 0xAA reaches the output, then reset strikes between edges.
    @(negedge clk); din = 8'hAA;
    @(negedge clk); din = 8'h00;
    @(negedge clk);
    @(negedge clk);
    check("aa_in_flight", {24'd0, dout}, 32'hAA);
    mid_reset();
    repeat (5) @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      logic [15:0] v;
      v = 16'($urandom);
      din16 = v;
      #1;
      check("comb_rand", {16'd0, dout16}, {16'd0, v});
    end

`ifdef DELAY_STALL_EN
    @(negedge clk); en = 1'b1; din = 8'h05;
    repeat (3) begin
      @(negedge clk); en = 1'b0; din = 8'($urandom);
    end
    repeat (3) begin
      @(negedge clk); en = 1'b1; din = 8'h00;
    end
`endif

    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      din  = 8'($urandom);
      din1 = 1'($urandom);
`ifdef DELAY_STALL_EN
      en   = ($urandom_range(0, 3) != 0);
`endif
      if ($urandom_range(0, 49) == 0) mid_reset();
    end

    en = 1'b1;
    repeat (6) @(negedge clk);
    for (int t = 0; t < 20 && exp_q.size() != 0; t++) @(posedge clk);
    #2;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
